// File: rtl/can_encoder.sv
// can_encoder: CAN 2.0A/2.0B bit-level frame transmitter. It serialises one bit per
// tx_point and handles bit stuffing, CRC-15, the ACK-slot check and the fixed trailer fields.
module can_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_point,
   input  logic        sample_point,
   input  logic        rx_bit,
   input  logic        start,
   input  logic [10:0] id_a,
   input  logic        ide,
   input  logic [17:0] id_b,
   input  logic        rtr,
   input  logic [3:0]  dlc,
   input  logic [63:0] data,
   output logic        tx_bit,
   output logic        busy,
   output logic        done,
   output logic        ack_error
);
   typedef enum logic [3:0] {
      IDLE, HEADER, DATA, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, IFS
   } state_t;

   // state/cnt name the field and remaining count of the NEXT bit to be driven
   state_t      state, state_n;
   logic [5:0]  cnt, cnt_n;
   logic [2:0]  run;
   logic        last;
   logic [38:0] hdr_sr;
   logic [63:0] data_sr;
   logic [14:0] crc;
   logic        rtr_q;
   logic [3:0]  dlc_q;
   logic        ack_now;
   logic        stuffed, stuff_now, field_bit, out_bit;
   logic [2:0]  dlc_m1;
   logic [5:0]  data_last;

   assign dlc_m1    = dlc_q[2:0] - 3'd1;
   assign data_last = dlc_q[3] ? 6'd63 : {dlc_m1, 3'b111};
   assign busy      = (state != IDLE);

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      stuffed   = (state == HEADER) || (state == DATA) || (state == CRC);
      case (state)
         HEADER:  field_bit = hdr_sr[38];
         DATA:    field_bit = data_sr[63];
         CRC:     field_bit = crc[14];
         default: field_bit = 1'b1;
      endcase
      stuff_now = stuffed && (run == 3'd5);
      out_bit   = stuff_now ? ~last : field_bit;

      if (state == IDLE) begin
         if (start) begin
            state_n = HEADER;
            cnt_n   = ide ? 6'd38 : 6'd18;
         end
      end else if (tx_point && !stuff_now) begin
         if (cnt != 6'd0) begin
            cnt_n = cnt - 6'd1;
         end else begin
            case (state)
               HEADER: begin
                  if (rtr_q || dlc_q == 4'd0) begin
                     state_n = CRC;
                     cnt_n   = 6'd14;
                  end else begin
                     state_n = DATA;
                     cnt_n   = data_last;
                  end
               end
               DATA:     begin state_n = CRC;      cnt_n = 6'd14; end
               CRC:      begin state_n = CRC_DEL;  cnt_n = 6'd0;  end
               CRC_DEL:  begin state_n = ACK_SLOT; cnt_n = 6'd0;  end
               ACK_SLOT: begin state_n = ACK_DEL;  cnt_n = 6'd0;  end
               ACK_DEL:  begin state_n = EOF;      cnt_n = 6'd6;  end
               // IFS loads 3 so its cnt==0 tick is the bit after the third IFS bit
               EOF:      begin state_n = IFS;      cnt_n = 6'd3;  end
               default:  begin state_n = IDLE;     cnt_n = 6'd0;  end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 6'd0;
         tx_bit    <= 1'b1;
         done      <= 1'b0;
         ack_error <= 1'b0;
         ack_now   <= 1'b0;
         run       <= 3'd0;
         last      <= 1'b1;
         crc       <= 15'd0;
         hdr_sr    <= 39'd0;
         data_sr   <= 64'd0;
         rtr_q     <= 1'b0;
         dlc_q     <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         done  <= 1'b0;
         if (state == IDLE && start) begin
            hdr_sr    <= ide ? {1'b0, id_a, 1'b1, 1'b1, id_b, rtr, 2'b00, dlc}
                             : {1'b0, id_a, rtr, 2'b00, dlc, 20'd0};
            data_sr   <= data;
            rtr_q     <= rtr;
            dlc_q     <= dlc;
            crc       <= 15'd0;
            run       <= 3'd0;
            last      <= 1'b1;
            ack_error <= 1'b0;
            ack_now   <= 1'b0;
         end
         // ack_now still marks the bit being replaced when both strobes coincide
         if (sample_point && ack_now)
            ack_error <= rx_bit;
         if (state != IDLE && tx_point) begin
            tx_bit  <= out_bit;
            ack_now <= (state == ACK_SLOT);
            if (state == IFS && cnt == 6'd0)
               done <= 1'b1;
            if (stuffed) begin
               if (stuff_now) begin
                  last <= ~last;
                  run  <= 3'd1;
               end else begin
                  last <= field_bit;
                  run  <= (field_bit == last) ? run + 3'd1 : 3'd1;
               end
            end
            if (!stuff_now) begin
               case (state)
                  HEADER: begin
                     hdr_sr <= {hdr_sr[37:0], 1'b0};
                     crc    <= {crc[13:0], 1'b0} ^ ({15{field_bit ^ crc[14]}} & 15'h4599);
                  end
                  DATA: begin
                     data_sr <= {data_sr[62:0], 1'b0};
                     crc     <= {crc[13:0], 1'b0} ^ ({15{field_bit ^ crc[14]}} & 15'h4599);
                  end
                  CRC:     crc <= {crc[13:0], 1'b0};
                  default: ;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_can_encoder.sv
// tb_can_encoder: directed plus random frames against a sequence-level CAN frame model
// (polynomial long division for CRC, list-based stuffing, receive-side destuff/decode).
module tb_can_encoder;
   typedef struct {
      logic [10:0] id_a;
      logic        ide;
      logic [17:0] id_b;
      logic        rtr;
      logic [3:0]  dlc;
      logic [63:0] data;
   } frame_t;

   localparam logic [15:0] GPOLY = 16'hC599;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_point = 1'b0;
   logic        sample_point = 1'b0;
   logic        rx_bit;
   logic        start;
   logic [10:0] id_a;
   logic        ide;
   logic [17:0] id_b;
   logic        rtr;
   logic [3:0]  dlc;
   logic [63:0] data;
   logic        tx_bit, busy, done, ack_error;

   int   n_assert = 0;
   int   n_fail = 0;
   int   phase = 0;
   logic exp_q[$];
   logic got_q[$];
   int   exp_ack_idx;

   can_encoder dut (
      .clk(clk), .rst(rst), .tx_point(tx_point), .sample_point(sample_point),
      .rx_bit(rx_bit), .start(start), .id_a(id_a), .ide(ide), .id_b(id_b),
      .rtr(rtr), .dlc(dlc), .data(data), .tx_bit(tx_bit), .busy(busy),
      .done(done), .ack_error(ack_error)
   );

   always #5 clk = ~clk;

   // bit period of 6 clocks: tx_point at phase 0, sample_point mid-bit
   always @(negedge clk) begin
      phase = (phase == 5) ? 0 : phase + 1;
      tx_point = (phase == 0);
      sample_point = (phase == 3);
   end

   task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic frame_t mk(input logic [10:0] a, input logic e, input logic [17:0] b,
                                 input logic r, input logic [3:0] d, input logic [63:0] p);
      frame_t f;
      f.id_a = a; f.ide = e; f.id_b = b; f.rtr = r; f.dlc = d; f.data = p;
      return f;
   endfunction

   function automatic int data_len(input frame_t f);
      if (f.rtr || f.dlc == 4'd0) return 0;
      return 8 * ((f.dlc > 4'd8) ? 8 : int'(f.dlc));
   endfunction

   // remainder of m(x) mod G(x) by long division; last 15 positions, MSB first
   function automatic logic [14:0] poly_rem(input logic m[$]);
      logic w[$];
      logic [14:0] r;
      w = m;
      for (int i = 0; i + 16 <= w.size(); i++)
         if (w[i])
            for (int j = 0; j < 16; j++) w[i+j] = w[i+j] ^ GPOLY[15-j];
      for (int k = 0; k < 15; k++) r[14-k] = w[w.size()-15+k];
      return r;
   endfunction

   task automatic build_exp(input frame_t f);
      logic u[$];
      logic m[$];
      logic [14:0] c;
      int run;
      logic prev;
      u.push_back(1'b0);
      for (int k = 10; k >= 0; k--) u.push_back(f.id_a[k]);
      if (f.ide) begin
         u.push_back(1'b1); u.push_back(1'b1);
         for (int k = 17; k >= 0; k--) u.push_back(f.id_b[k]);
         u.push_back(f.rtr); u.push_back(1'b0); u.push_back(1'b0);
      end else begin
         u.push_back(f.rtr); u.push_back(1'b0); u.push_back(1'b0);
      end
      for (int k = 3; k >= 0; k--) u.push_back(f.dlc[k]);
      for (int k = 0; k < data_len(f); k++) u.push_back(f.data[63-k]);
      m = u;
      repeat (15) m.push_back(1'b0);
      c = poly_rem(m);
      for (int k = 14; k >= 0; k--) u.push_back(c[k]);
      exp_q.delete();
      run = 0;
      prev = 1'b1;
      foreach (u[i]) begin
         exp_q.push_back(u[i]);
         run = (run > 0 && u[i] === prev) ? run + 1 : 1;
         prev = u[i];
         if (run == 5 && i != u.size() - 1) begin
            exp_q.push_back(!u[i]);
            prev = !u[i];
            run = 1;
         end
      end
      exp_ack_idx = exp_q.size() + 1;
      repeat (13) exp_q.push_back(1'b1);
   endtask

   task automatic apply(input frame_t f);
      id_a = f.id_a; ide = f.ide; id_b = f.id_b; rtr = f.rtr; dlc = f.dlc; data = f.data;
   endtask

   task automatic scramble();
      id_a = 11'($urandom); ide = 1'($urandom); id_b = 18'($urandom); rtr = 1'($urandom);
      dlc = 4'($urandom); data = {$urandom, $urandom};
   endtask

   // receive-side destuff and field decode of the captured stream
   task automatic decode(input frame_t f, input string tag);
      logic u[$];
      int run = 0, need = 14, hdr = 0, i = 0, serr = 0, dl = -1;
      logic prev = 1'b1;
      logic [3:0] dlc_f;
      logic rtr_f;
      logic [63:0] gd, mask;
      while (u.size() < need && i < got_q.size()) begin
         logic b;
         b = got_q[i];
         i++;
         if (run == 5) begin
            if (b === prev) serr++;
            prev = b;
            run = 1;
         end else begin
            run = (run > 0 && b === prev) ? run + 1 : 1;
            prev = b;
            u.push_back(b);
            if (u.size() == 14) begin
               hdr = u[13] ? 39 : 19;
               need = hdr;
            end else if (hdr != 0 && dl < 0 && u.size() == hdr) begin
               dlc_f = {u[hdr-4], u[hdr-3], u[hdr-2], u[hdr-1]};
               rtr_f = (hdr == 39) ? u[32] : u[12];
               dl = (rtr_f || dlc_f == 4'd0) ? 0 : 8 * ((dlc_f > 4'd8) ? 8 : int'(dlc_f));
               need = hdr + dl + 15;
            end
         end
      end
      chk(serr, 0, {tag, " stuff_rule"});
      chk(u.size(), hdr + data_len(f) + 15, {tag, " destuffed_len"});
      if (dl >= 0 && u.size() == need) begin
         chk(u[13], f.ide, {tag, " ide"});
         if (f.ide) chk(u[12], 1, {tag, " srr"});
         chk(dlc_f, f.dlc, {tag, " dlc_field"});
         chk(rtr_f, f.rtr, {tag, " rtr"});
         chk(dl, data_len(f), {tag, " data_bits"});
         gd = '0;
         mask = '0;
         for (int k = 0; k < dl; k++) begin
            gd[63-k] = u[hdr+k];
            mask[63-k] = 1'b1;
         end
         chk(gd, f.data & mask, {tag, " data"});
         chk(poly_rem(u), 0, {tag, " crc_residue"});
      end
   endtask

   task automatic run_frame(input frame_t f, input bit ack_dom, input int poke_at, input string tag);
      int cyc = 0;
      bit fin = 0, poked = 0, bad = 0;
      build_exp(f);
      got_q.delete();
      rx_bit = 1'b1;
      @(negedge clk);
      apply(f);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble();
      chk(busy, 1, {tag, " busy_after_start"});
      while (!fin && cyc < 4000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (poked) begin
            start = 1'b0;
            poked = 0;
         end
         if (tx_point) begin
            if (done) fin = 1;
            else begin
               got_q.push_back(tx_bit);
               rx_bit = (ack_dom && got_q.size() - 1 == exp_ack_idx) ? 1'b0 : 1'b1;
               if (got_q.size() == poke_at) begin
                  scramble();
                  start = 1'b1;
                  poked = 1;
               end
            end
         end
      end
      rx_bit = 1'b1;
      chk(fin, 1, {tag, " done_seen"});
      chk(tx_bit, 1, {tag, " tx_bit_at_done"});
      chk(busy, 0, {tag, " busy_at_done"});
      chk(got_q.size(), exp_q.size(), {tag, " frame_len"});
      for (int i = 0; i < got_q.size() && i < exp_q.size() && !bad; i++) begin
         n_assert++;
         assert (got_q[i] === exp_q[i]) else begin
            n_fail++;
            bad = 1;
            $error("FAIL %s bit%0d: observed %0b expected %0b", tag, i, got_q[i], exp_q[i]);
         end
      end
      decode(f, tag);
      chk(ack_error, !ack_dom, {tag, " ack_error"});
      @(posedge clk);
      #1;
      chk(done, 0, {tag, " done_one_clk"});
   endtask

   initial begin
      frame_t fz, fd, fx, fr;
      int seen, cnt, cyc;
      rst = 1'b0; start = 1'b1; rx_bit = 1'b1;
      apply(mk(11'h0, 1'b0, 18'h0, 1'b0, 4'd0, 64'h0));
      repeat (3) begin
         @(posedge clk);
         #1;
         chk(tx_bit, 1, "rst tx_bit");
         chk(busy, 0, "rst busy");
         chk(done, 0, "rst done");
      end
      @(negedge clk);
      start = 1'b0;
      rst = 1'b1;
      seen = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (busy !== 1'b0 || tx_bit !== 1'b1 || done !== 1'b0) seen++;
      end
      chk(seen, 0, "no frame after reset");

      fz = mk(11'h0, 1'b0, 18'h0, 1'b0, 4'd0, 64'h0);
      run_frame(fz, 0, -1, "zero");
      chk(got_q.size(), 53, "zero 53 bits");
      chk(ack_error, 1, "zero ack recessive");
      run_frame(fz, 1, -1, "ack");
      chk(ack_error, 0, "ack dominant");

      fd = mk(11'h123, 1'b0, 18'h0, 1'b0, 4'd2, {16'hA55A, 48'h0123_4567_89AB});
      run_frame(fd, 1, -1, "data");
      fx = mk(11'h7FF, 1'b1, 18'h3FFFF, 1'b1, 4'd12, {$urandom, $urandom});
      run_frame(fx, 1, -1, "ext_rtr");
      chk(got_q.size() > 6 ? {got_q[0], got_q[1], got_q[5], got_q[6]} : 4'hF, 4'b0110, "ext first stuff");

      run_frame(fd, 1, 10, "start_while_busy");

      // reset in the middle of the data field
      @(negedge clk);
      apply(fd);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      cyc = 0;
      while (cnt < 28 && cyc < 1000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (tx_point) cnt++;
      end
      chk(cnt, 28, "mid reset reach data");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk(tx_bit, 1, "mid reset tx_bit");
      chk(busy, 0, "mid reset busy");
      chk(done, 0, "mid reset done");
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      repeat (60) begin
         @(posedge clk);
         #1;
         if (done !== 1'b0 || busy !== 1'b0 || tx_bit !== 1'b1) seen++;
      end
      chk(seen, 0, "mid reset quiet");
      run_frame(fd, 1, -1, "after_reset");

      for (int n = 0; n < 8; n++) begin
         fr = mk(11'($urandom), 1'($urandom), 18'($urandom), 1'($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)), {$urandom, $urandom});
         run_frame(fr, 1'($urandom), -1, $sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
